// File: rtl/user_stream_engine.sv
// rtl/user_stream_engine.sv - per-channel loopback FIFO / pattern stream engine with register file and threshold interrupt
// Channels are either FWFT loopback FIFOs or free-running pattern sources, selected through CTRL.
module user_stream_engine #(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 16,
    parameter int REG_BASE   = 'h400
) (
    input  logic                     i_pcie_clk,
    input  logic                     i_rst,
    input  logic [31:0]              i_user_data,
    input  logic [19:0]              i_user_addr,
    input  logic                     i_user_wr_req,
    input  logic                     i_user_rd_req,
    output logic [31:0]              o_user_data,
    output logic                     o_user_rd_ack,
    input  logic [NUM_CH-1:0]        i_str_data_valid,
    output logic [NUM_CH-1:0]        o_str_ack,
    input  logic [NUM_CH*DATA_W-1:0] i_str_data,
    output logic [NUM_CH-1:0]        o_str_data_valid,
    input  logic [NUM_CH-1:0]        i_str_ack,
    output logic [NUM_CH*DATA_W-1:0] o_str_data,
    output logic                     o_intr_req,
    input  logic                     i_intr_ack
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [19:0] BASE = 20'(REG_BASE);

    logic [NUM_CH-1:0] ch_en;
    logic [NUM_CH-1:0] ch_mode;
    logic [31:0]       thresh;
    logic [31:0]       cnt [NUM_CH];
    logic [63:0]       pat [NUM_CH];
    logic [DATA_W-1:0] mem [NUM_CH][FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr [NUM_CH];
    logic [AW-1:0]     rd_ptr [NUM_CH];
    logic [AW:0]       fill [NUM_CH];
    logic              pending;

    logic [19:0]       off;
    logic              wr_ctrl;
    logic              wr_thresh;
    logic [NUM_CH-1:0] wr_cnt;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] flush;
    logic [NUM_CH-1:0] ack_v;
    logic [NUM_CH-1:0] vld_v;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] beat;
    logic [NUM_CH-1:0] hit;
    logic [DATA_W+63:0] ext;
    logic [31:0]       rdata;

    assign off        = i_user_addr - BASE;
    assign o_intr_req = pending;

    always_comb begin
        wr_ctrl    = i_user_wr_req && (off == 20'h0);
        wr_thresh  = i_user_wr_req && (off == 20'h4);
        wr_cnt     = '0;
        empty      = '0;
        full       = '0;
        flush      = '0;
        ack_v      = '0;
        vld_v      = '0;
        push       = '0;
        pop        = '0;
        beat       = '0;
        hit        = '0;
        ext        = '0;
        o_str_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            wr_cnt[c] = i_user_wr_req && (off == 20'(16 + 4 * c));
            empty[c]  = (fill[c] == '0);
            full[c]   = (fill[c] == (AW+1)'(FIFO_DEPTH));
            // A mode flip flushes the channel and swallows any handshake in that cycle.
            flush[c]  = wr_ctrl && (i_user_data[8+c] != ch_mode[c]);
            ack_v[c]  = ch_en[c] && (ch_mode[c] || !full[c]);
            vld_v[c]  = ch_en[c] && (ch_mode[c] || !empty[c]);
            push[c]   = i_str_data_valid[c] && ack_v[c] && !ch_mode[c] && !flush[c];
            beat[c]   = vld_v[c] && i_str_ack[c] && !flush[c];
            pop[c]    = beat[c] && !ch_mode[c];
            hit[c]    = beat[c] && !wr_cnt[c] && (thresh != 32'd0) && (cnt[c] + 32'd1 == thresh);
            ext       = {{DATA_W{1'b0}}, pat[c]};
            if (!ch_en[c])
                o_str_data[c*DATA_W +: DATA_W] = '0;
            else if (ch_mode[c])
                o_str_data[c*DATA_W +: DATA_W] = ext[DATA_W-1:0];
            else
                o_str_data[c*DATA_W +: DATA_W] = mem[c][rd_ptr[c]];
        end
    end

    assign o_str_ack        = ack_v;
    assign o_str_data_valid = vld_v;

    always_comb begin
        rdata = '0;
        if (off == 20'h0) begin
            for (int c = 0; c < NUM_CH; c++) begin
                rdata[c]   = ch_en[c];
                rdata[8+c] = ch_mode[c];
            end
        end else if (off == 20'h4) begin
            rdata = thresh;
        end else if (off == 20'h8) begin
            for (int c = 0; c < NUM_CH; c++) begin
                rdata[c]   = empty[c];
                rdata[8+c] = full[c];
            end
            rdata[16] = pending;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (off == 20'(16 + 4 * c))
                    rdata = cnt[c];
            end
        end
    end

    always_ff @(posedge i_pcie_clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (push[c])
                mem[c][wr_ptr[c]] <= i_str_data[c*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge i_pcie_clk) begin
        if (i_rst) begin
            ch_en         <= '0;
            ch_mode       <= '0;
            thresh        <= '0;
            pending       <= 1'b0;
            o_user_rd_ack <= 1'b0;
            o_user_data   <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                cnt[c]    <= '0;
                pat[c]    <= '0;
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                fill[c]   <= '0;
            end
        end else begin
            if (wr_ctrl) begin
                ch_en   <= i_user_data[NUM_CH-1:0];
                ch_mode <= i_user_data[8 +: NUM_CH];
            end
            if (wr_thresh)
                thresh <= i_user_data;
            for (int c = 0; c < NUM_CH; c++) begin
                if (flush[c]) begin
                    wr_ptr[c] <= '0;
                    rd_ptr[c] <= '0;
                    fill[c]   <= '0;
                    pat[c]    <= '0;
                end else begin
                    if (push[c])
                        wr_ptr[c] <= wr_ptr[c] + AW'(1);
                    if (pop[c])
                        rd_ptr[c] <= rd_ptr[c] + AW'(1);
                    fill[c] <= fill[c] + (AW+1)'(push[c]) - (AW+1)'(pop[c]);
                    if (beat[c] && ch_mode[c])
                        pat[c] <= pat[c] + 64'd1;
                end
                if (wr_cnt[c])
                    cnt[c] <= '0;
                else if (beat[c])
                    cnt[c] <= cnt[c] + 32'd1;
            end
            // A fresh threshold hit outranks a concurrent acknowledge.
            pending       <= (|hit) || (pending && !i_intr_ack);
            o_user_rd_ack <= i_user_rd_req;
            o_user_data   <= i_user_rd_req ? rdata : '0;
        end
    end

endmodule
